// File: rtl/mold_tx_pack.sv
// MoldUDP64 transmit packetizer: wraps one AXI-stream message into a single-message
// MoldUDP64 payload (session, sequence, count=1, length, message bytes).
module mold_tx_pack #(
  parameter int unsigned AXI_DATA_W = 64,
  parameter int unsigned AXI_KEEP_W = AXI_DATA_W/8,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned SID_W      = 80,
  parameter int unsigned SEQ_W      = 64
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [SID_W-1:0]      sid_i,
  input  logic                  seq_load_v_i,
  input  logic [SEQ_W-1:0]      seq_i,
  input  logic                  msg_valid_i,
  output logic                  msg_ready_o,
  input  logic [AXI_DATA_W-1:0] msg_data_i,
  input  logic [AXI_KEEP_W-1:0] msg_keep_i,
  input  logic                  msg_last_i,
  input  logic [LEN_W-1:0]      msg_len_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [AXI_DATA_W-1:0] m_data_o,
  output logic [AXI_KEEP_W-1:0] m_keep_o,
  output logic                  m_last_o,
  output logic                  len_err_o
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, BODY, TAIL} state_t;

  function automatic logic [63:0] bswap(input logic [63:0] v);
    logic [63:0] r;
    for (int unsigned i = 0; i < 8; i++) r[8*i +: 8] = v[63-8*i -: 8];
    return r;
  endfunction

  function automatic logic [3:0] pop8(input logic [7:0] k);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < 8; i++) c = c + {3'b000, k[i]};
    return c;
  endfunction

  function automatic logic [7:0] therm(input logic [3:0] n);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) r[i] = (i < 32'(n));
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, byte_cnt, cnt_sum;
  logic [SEQ_W-1:0]        seq_q, seq_snap, seq_nxt;
  logic [47:0]             prev_q;
  logic [3:0]              tail_n, n_in;
  logic                    len_err_q;
  logic                    m_valid_q, m_last_q;
  logic [AXI_DATA_W-1:0]   m_data_q, d_data;
  logic [AXI_KEEP_W-1:0]   m_keep_q, d_keep;
  logic                    d_last, ld, adv, acc, start, last_fire;

  assign adv         = ~m_valid_q | m_ready_i;
  assign msg_ready_o = ((state_q == HDR2) || (state_q == BODY)) && adv;
  assign acc         = msg_valid_i & msg_ready_o;
  assign n_in        = pop8(msg_keep_i);
  assign cnt_sum     = byte_cnt + LEN_W'(n_in);
  assign last_fire   = m_valid_q & m_last_q & m_ready_i;
  assign seq_nxt     = seq_load_v_i ? seq_i : (last_fire ? seq_q + SEQ_W'(1) : seq_q);
  // Hold off a new packet while the previous last beat is still stalled, so the
  // snapshot below always sees the sequence number after that beat's increment.
  assign start       = msg_valid_i & ~(m_valid_q & m_last_q & ~m_ready_i);

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_keep_o  = m_keep_q;
  assign m_last_o  = m_last_q;
  assign len_err_o = len_err_q;

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    d_data  = '0;
    d_keep  = '0;
    d_last  = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = HDR0;
      HDR0: if (adv) begin
        ld      = 1'b1;
        d_data  = bswap(sid_i[79:16]);
        d_keep  = '1;
        state_d = HDR1;
      end
      HDR1: if (adv) begin
        ld      = 1'b1;
        d_data  = bswap({sid_i[15:0], seq_snap[63:16]});
        d_keep  = '1;
        state_d = HDR2;
      end
      HDR2, BODY: if (acc) begin
        ld = 1'b1;
        if (state_q == HDR2)
          d_data = bswap({seq_snap[15:0], 16'h0001, len_q, msg_data_i[7:0], msg_data_i[15:8]});
        else
          d_data = {msg_data_i[15:0], prev_q};
        if (!msg_last_i) begin
          d_keep  = '1;
          state_d = BODY;
        end else if (n_in <= 4'd2) begin
          d_keep  = therm(n_in + 4'd6);
          d_last  = 1'b1;
          state_d = IDLE;
        end else begin
          d_keep  = '1;
          state_d = TAIL;
        end
      end
      TAIL: if (adv) begin
        ld      = 1'b1;
        d_data  = {16'h0000, prev_q};
        d_keep  = therm(tail_n - 4'd2);
        d_last  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      seq_q     <= SEQ_W'(1);
      seq_snap  <= '0;
      prev_q    <= '0;
      tail_n    <= '0;
      byte_cnt  <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_nxt;
      len_err_q <= acc & msg_last_i & (cnt_sum != len_q);
      if (state_q == IDLE && start) begin
        len_q    <= msg_len_i;
        seq_snap <= seq_nxt;
      end
      if (state_q == IDLE) byte_cnt <= '0;
      else if (acc)        byte_cnt <= cnt_sum;
      if (acc) begin
        prev_q <= msg_data_i[63:16];
        if (msg_last_i) tail_n <= n_in;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
    end else if (ld) begin
      m_valid_q <= 1'b1;
      m_data_q  <= d_data;
      m_keep_q  <= d_keep;
      m_last_q  <= d_last;
    end else if (m_ready_i) begin
      m_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mold_tx_pack.sv
// Directed bench for mold_tx_pack: expected payloads are rebuilt byte by byte from
// session/sequence/length/message and chunked into 8-byte beats.
module tb_mold_tx_pack;

  localparam logic [79:0] SID = 80'h0102030405060708090A;

  logic        clk = 1'b0;
  logic        nreset;
  logic [79:0] sid_i;
  logic        seq_load_v_i;
  logic [63:0] seq_i;
  logic        msg_valid_i;
  logic        msg_ready_o;
  logic [63:0] msg_data_i;
  logic [7:0]  msg_keep_i;
  logic        msg_last_i;
  logic [15:0] msg_len_i;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [63:0] m_data_o;
  logic [7:0]  m_keep_o;
  logic        m_last_o;
  logic        len_err_o;

  logic        rdy_mode = 1'b0;
  logic        tog = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [63:0] obs_d [0:255];
  logic [7:0]  obs_k [0:255];
  logic        obs_l [0:255];
  int          obs_n = 0;
  int          err_pulses = 0;
  int          rd_idx;
  logic [7:0]  msg_b [0:63];

  mold_tx_pack #(.AXI_DATA_W(64), .LEN_W(16), .SID_W(80), .SEQ_W(64)) dut (
    .clk(clk), .nreset(nreset), .sid_i(sid_i), .seq_load_v_i(seq_load_v_i), .seq_i(seq_i),
    .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o), .msg_data_i(msg_data_i),
    .msg_keep_i(msg_keep_i), .msg_last_i(msg_last_i), .msg_len_i(msg_len_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_keep_o(m_keep_o),
    .m_last_o(m_last_o), .len_err_o(len_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin #1; tog = ~tog; end
  assign m_ready_i = rdy_mode ? tog : 1'b1;

  // Output beats are recorded at the falling edge preceding the rising edge that transfers them.
  always @(negedge clk) begin
    if (nreset && m_valid_o && m_ready_i && obs_n < 256) begin
      obs_d[obs_n] = m_data_o;
      obs_k[obs_n] = m_keep_o;
      obs_l[obs_n] = m_last_o;
      obs_n = obs_n + 1;
    end
    if (nreset && len_err_o) err_pulses = err_pulses + 1;
  end

  function automatic logic [7:0] th(input int n);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (i < n);
    return r;
  endfunction

  function automatic logic [63:0] kmask(input logic [7:0] k);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic [15:0] len);
    logic accepted;
    accepted = 1'b0;
    @(posedge clk); #1;
    msg_valid_i = 1'b1; msg_data_i = d; msg_keep_i = k; msg_last_i = l; msg_len_i = len;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (msg_ready_o) begin accepted = 1'b1; break; end
    end
    chk("beat_accept", 64'(accepted), 64'd1);
    @(posedge clk); #1;
    msg_valid_i = 1'b0; msg_last_i = 1'b0;
  endtask

  task automatic send_msg(input int L, input logic [15:0] len);
    int nb;
    logic [63:0] d;
    nb = (L + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      for (int i = 0; i < 8; i++) if (8*b + i < L) d[8*i +: 8] = msg_b[8*b + i];
      send_beat(d, th((L - 8*b) > 8 ? 8 : (L - 8*b)), (b == nb - 1), len);
    end
  endtask

  task automatic check_pkt(input string tag, input logic [63:0] seq, input logic [15:0] lenf,
                           input int L);
    logic [7:0]  pay [0:127];
    logic [63:0] ed;
    logic [7:0]  ek;
    int nb, tot, rem;
    for (int i = 0; i < 10; i++) pay[i] = SID[79 - 8*i -: 8];
    for (int i = 0; i < 8; i++)  pay[10 + i] = seq[63 - 8*i -: 8];
    pay[18] = 8'h00; pay[19] = 8'h01; pay[20] = lenf[15:8]; pay[21] = lenf[7:0];
    for (int i = 0; i < L; i++) pay[22 + i] = msg_b[i];
    tot = 22 + L;
    nb  = (tot + 7) / 8;
    for (int c = 0; c < 400; c++) begin
      if (obs_n - rd_idx >= nb) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk({tag, "_nbeats"}, 64'(obs_n - rd_idx), 64'(nb));
    for (int b = 0; b < nb; b++) begin
      if (rd_idx + b < obs_n) begin
        rem = tot - 8*b;
        ek  = th(rem > 8 ? 8 : rem);
        ed  = '0;
        for (int i = 0; i < 8; i++) if (i < rem) ed[8*i +: 8] = pay[8*b + i];
        chk({tag, "_data"}, obs_d[rd_idx + b] & kmask(ek), ed);
        chk({tag, "_keep"}, 64'(obs_k[rd_idx + b]), 64'(ek));
        chk({tag, "_last"}, 64'(obs_l[rd_idx + b]), 64'(b == nb - 1));
      end
    end
    rd_idx = obs_n;
  endtask

  initial begin
    int b0, e0;
    nreset = 1'b0; sid_i = SID; seq_load_v_i = 1'b0; seq_i = '0;
    msg_valid_i = 1'b0; msg_data_i = '0; msg_keep_i = '0; msg_last_i = 1'b0; msg_len_i = '0;
    rd_idx = 0;
    #3;
    chk("rst_m_valid", 64'(m_valid_o), 64'd0);
    chk("rst_m_data", m_data_o, 64'd0);
    chk("rst_m_keep", 64'(m_keep_o), 64'd0);
    chk("rst_m_last", 64'(m_last_o), 64'd0);
    chk("rst_msg_ready", 64'(msg_ready_o), 64'd0);
    chk("rst_len_err", 64'(len_err_o), 64'd0);
    repeat (3) @(negedge clk);
    nreset = 1'b1;

    // 2-byte message: header beat holds the whole message
    msg_b[0] = 8'hAA; msg_b[1] = 8'hBB;
    b0 = rd_idx; e0 = err_pulses;
    send_msg(2, 16'd2);
    check_pkt("t1", 64'd1, 16'd2, 2);
    chk("t1_beat2_hand", obs_d[b0 + 2], 64'hBBAA020001000100);
    chk("t1_beat2_keep", 64'(obs_k[b0 + 2]), 64'hFF);
    chk("t1_len_err", 64'(err_pulses - e0), 64'd0);

    // 11 bytes: last input beat carries 3 bytes, one spills into a tail beat
    for (int i = 0; i < 11; i++) msg_b[i] = 8'(8'h10 + i);
    b0 = rd_idx;
    send_msg(11, 16'd11);
    check_pkt("t2", 64'd2, 16'd11, 11);
    chk("t2_tail_keep", 64'(obs_k[b0 + 4]), 64'h01);

    // 16 bytes under a toggling downstream ready
    for (int i = 0; i < 16; i++) msg_b[i] = 8'(8'h30 + i);
    b0 = rd_idx;
    rdy_mode = 1'b1;
    send_msg(16, 16'd16);
    check_pkt("t3", 64'd3, 16'd16, 16);
    rdy_mode = 1'b0;
    chk("t3_tail_keep", 64'(obs_k[b0 + 4]), 64'h3F);

    // sequence load and wrap
    @(posedge clk); #1; seq_load_v_i = 1'b1; seq_i = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1; seq_load_v_i = 1'b0; seq_i = '0;
    for (int i = 0; i < 5; i++) msg_b[i] = 8'(8'h40 + i);
    send_msg(5, 16'd5);
    check_pkt("t4a", 64'hFFFF_FFFF_FFFF_FFFF, 16'd5, 5);
    send_msg(5, 16'd5);
    check_pkt("t4b", 64'd0, 16'd5, 5);

    // declared length 20, only 10 bytes delivered
    for (int i = 0; i < 10; i++) msg_b[i] = 8'(8'h50 + i);
    e0 = err_pulses;
    send_msg(10, 16'd20);
    check_pkt("t5", 64'd1, 16'h0014, 10);
    chk("t5_len_err_pulses", 64'(err_pulses - e0), 64'd1);

    // reset while in BODY
    for (int i = 0; i < 24; i++) msg_b[i] = 8'(8'h60 + i);
    send_beat({msg_b[7], msg_b[6], msg_b[5], msg_b[4], msg_b[3], msg_b[2], msg_b[1], msg_b[0]},
              8'hFF, 1'b0, 16'd24);
    send_beat({msg_b[15], msg_b[14], msg_b[13], msg_b[12], msg_b[11], msg_b[10], msg_b[9], msg_b[8]},
              8'hFF, 1'b0, 16'd24);
    chk("t6_pre_reset_valid", 64'(m_valid_o), 64'd1);
    #2; nreset = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(m_valid_o), 64'd0);
    chk("t6_rst_ready", 64'(msg_ready_o), 64'd0);
    chk("t6_rst_keep", 64'(m_keep_o), 64'd0);
    chk("t6_rst_last", 64'(m_last_o), 64'd0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    rd_idx = obs_n;
    repeat (3) @(negedge clk);
    chk("t6_no_tail", 64'(obs_n - rd_idx), 64'd0);
    msg_b[0] = 8'hC1; msg_b[1] = 8'hC2;
    send_msg(2, 16'd2);
    check_pkt("t6", 64'd1, 16'd2, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
